// File: rtl/multi_controller_poller_if.sv
// Bundle of the poller's host-side and pad-side signals.
// The poller connects through the master modport; the host and pads use the slave modport.
interface multi_controller_poller_if #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int BUTTONS         = 8
);
  localparam int IW = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1;

  logic                               poll_start;
  logic [NUM_CONTROLLERS-1:0]         data_in_B;
  logic                               controller_clk;
  logic                               controller_latch;
  logic                               busy;
  logic                               valid;
  logic [NUM_CONTROLLERS*BUTTONS-1:0] buttons_out;
  logic [IW-1:0]                      cpu_index;
  logic [BUTTONS-1:0]                 cpu_buttons;
  logic [NUM_CONTROLLERS*BUTTONS-1:0] pressed_edge;

  modport master (
    input  poll_start, data_in_B, cpu_index,
    output controller_clk, controller_latch, busy, valid,
           buttons_out, cpu_buttons, pressed_edge
  );

  modport slave (
    output poll_start, data_in_B, cpu_index,
    input  controller_clk, controller_latch, busy, valid,
           buttons_out, cpu_buttons, pressed_edge
  );
endinterface

// File: rtl/multi_controller_poller.sv
// Serial shift-register pad reader: one shared clk/latch pair drives NUM_CONTROLLERS pads.
// Define MULTI_CONTROLLER_POLLER_EDGE_EN to enable the newly-pressed (pressed_edge) registers.
module multi_controller_poller #(
  parameter int NUM_CONTROLLERS  = 2,
  parameter int BUTTONS          = 8,
  parameter int HALF_PERIOD      = 2,
  parameter int AUTO_POLL_PERIOD = 0
) (
  input  logic                     clk_1,
  input  logic                     rst,
  multi_controller_poller_if.master bus
);
  localparam int NUM = NUM_CONTROLLERS;
  localparam int B   = BUTTONS;
  localparam int H   = HALF_PERIOD;
  localparam int W   = NUM * B;
  localparam int IW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int PW  = $clog2(2 * H) + 1;
  localparam int KW  = $clog2(B) + 1;

  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * H - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(H - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(B - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LATCH = 3'd1;
  localparam logic [2:0] LOW   = 3'd2;
  localparam logic [2:0] HIGH  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic [KW-1:0] bit_reg, bit_next;
  logic [W-1:0]  shift_reg, shift_next;
  logic [W-1:0]  buttons_reg;
  logic          clk_out_reg;
  logic          latch_reg;
  logic          start;
  logic          auto_fire;
  logic          capture;
  logic          last_capture;
  logic [B-1:0]  cpu_word;

  assign start        = (state_reg == IDLE) && (bus.poll_start || auto_fire);
  assign capture      = (state_reg == LOW) && (phase_reg == HALF_LAST);
  assign last_capture = capture && (bit_reg == K_LAST);

  // Free-running self-start; only advances while idle so a slow poll never stacks requests.
  generate
    if (AUTO_POLL_PERIOD > 0) begin : g_auto
      localparam int AW = $clog2(AUTO_POLL_PERIOD) + 1;
      localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_POLL_PERIOD - 1);
      logic [AW-1:0] auto_reg;

      assign auto_fire = (state_reg == IDLE) && (auto_reg == AUTO_LAST);

      always_ff @(posedge clk_1) begin
        if (rst) begin
          auto_reg <= '0;
        end else if (start) begin
          auto_reg <= '0;
        end else if (state_reg == IDLE) begin
          auto_reg <= auto_reg + 1'b1;
        end
      end
    end else begin : g_no_auto
      assign auto_fire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg + 1'b1;
    bit_next   = bit_reg;
    case (state_reg)
      IDLE: begin
        phase_next = '0;
        if (start) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        if (phase_reg == LATCH_LAST) begin
          state_next = LOW;
          phase_next = '0;
          bit_next   = '0;
        end
      end
      LOW: begin
        if (capture) begin
          phase_next = '0;
          state_next = (bit_reg == K_LAST) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (phase_reg == HALF_LAST) begin
          phase_next = '0;
          state_next = LOW;
          bit_next   = bit_reg + 1'b1;
        end
      end
      DONE: begin
        phase_next = '0;
        state_next = IDLE;
      end
      default: begin
        phase_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // First bit shifted out of a pad is its MSB; pad lines are active low.
  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_pad
      for (genvar gj = 0; gj < B; gj++) begin : g_bit
        assign shift_next[gi*B + gj] = (capture && (bit_reg == KW'(B - 1 - gj)))
                                       ? ~bus.data_in_B[gi]
                                       : shift_reg[gi*B + gj];
      end
    end
  endgenerate

  // Published word is loaded together with the final bit so it is current while valid is high.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      buttons_reg <= '0;
      clk_out_reg <= 1'b0;
      latch_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      clk_out_reg <= (state_next == HIGH);
      latch_reg   <= (state_next == LATCH);
      if (last_capture) begin
        buttons_reg <= shift_next;
      end
    end
  end

`ifdef MULTI_CONTROLLER_POLLER_EDGE_EN
  logic [W-1:0] edge_reg;

  always_ff @(posedge clk_1) begin
    if (rst) begin
      edge_reg <= '0;
    end else if (last_capture) begin
      edge_reg <= shift_next & ~buttons_reg;
    end
  end

  assign bus.pressed_edge = edge_reg;
`else
  assign bus.pressed_edge = '0;
`endif

  always_comb begin
    cpu_word = '0;
    for (int i = 0; i < NUM; i++) begin
      if (bus.cpu_index == IW'(i)) begin
        cpu_word = buttons_reg[i*B +: B];
      end
    end
  end

  assign bus.controller_clk   = clk_out_reg;
  assign bus.controller_latch = latch_reg;
  assign bus.busy             = (state_reg != IDLE);
  assign bus.valid            = (state_reg == DONE);
  assign bus.buttons_out      = buttons_reg;
  assign bus.cpu_buttons      = cpu_word;
endmodule

// File: tb/tb_multi_controller_poller.sv
// Directed bench: a 2-pad/8-button/H=2 poller and a 3-pad/12-button/H=1 auto-polling one.
// Expected edge-detect results follow MULTI_CONTROLLER_POLLER_EDGE_EN.
`timescale 1ns/1ps
module tb_multi_controller_poller;
  localparam int N1 = 2, B1 = 8,  H1 = 2;
  localparam int N2 = 3, B2 = 12, H2 = 1;

`ifdef MULTI_CONTROLLER_POLLER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk_1 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_1 = ~clk_1;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  always @(posedge clk_1) cyc <= cyc + 1;

  multi_controller_poller_if #(.NUM_CONTROLLERS(N1), .BUTTONS(B1)) bus1();
  multi_controller_poller_if #(.NUM_CONTROLLERS(N2), .BUTTONS(B2)) bus2();

  multi_controller_poller #(
    .NUM_CONTROLLERS(N1), .BUTTONS(B1), .HALF_PERIOD(H1), .AUTO_POLL_PERIOD(0)
  ) dut1 (.clk_1(clk_1), .rst(rst), .bus(bus1.master));

  multi_controller_poller #(
    .NUM_CONTROLLERS(N2), .BUTTONS(B2), .HALF_PERIOD(H2), .AUTO_POLL_PERIOD(50)
  ) dut2 (.clk_1(clk_1), .rst(rst), .bus(bus2.master));

  // Pad models: parallel load while latch is high, advance one bit per shift-clock rise.
  logic [B1-1:0] pad1 [N1];
  int            pad1_cnt = 0;
  logic          pad1_clk_prev = 1'b0;
  always @(posedge clk_1) begin
    pad1_clk_prev <= bus1.controller_clk;
    if (bus1.controller_latch) pad1_cnt <= 0;
    else if (bus1.controller_clk && !pad1_clk_prev) pad1_cnt <= pad1_cnt + 1;
  end
  always_comb begin
    bus1.data_in_B = '1;
    for (int i = 0; i < N1; i++)
      if (pad1_cnt < B1) bus1.data_in_B[i] = ~pad1[i][B1-1-pad1_cnt];
  end

  logic [B2-1:0] pad2 [N2];
  int            pad2_cnt = 0;
  logic          pad2_clk_prev = 1'b0;
  always @(posedge clk_1) begin
    pad2_clk_prev <= bus2.controller_clk;
    if (bus2.controller_latch) pad2_cnt <= 0;
    else if (bus2.controller_clk && !pad2_clk_prev) pad2_cnt <= pad2_cnt + 1;
  end
  always_comb begin
    bus2.data_in_B = '1;
    for (int i = 0; i < N2; i++)
      if (pad2_cnt < B2) bus2.data_in_B[i] = ~pad2[i][B2-1-pad2_cnt];
  end

  // Cycle stamps of the first few valid pulses of the auto-polling instance.
  int v2_cnt = 0;
  int v2_at [4] = '{default: 0};
  always @(posedge clk_1) begin
    if (bus2.valid && v2_cnt < 4) begin
      v2_at[v2_cnt] <= cyc;
      v2_cnt        <= v2_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  // Pulse poll_start on instance 1 and wait for valid, tallying waveform cycles on the way.
  task automatic poll1(output int lat, output int nb, output int nl, output int nc);
    int c0;
    c0 = cyc;
    nb = 0; nl = 0; nc = 0;
    bus1.poll_start = 1'b1;
    do begin
      @(negedge clk_1);
      bus1.poll_start = 1'b0;
      nb += int'(bus1.busy);
      nl += int'(bus1.controller_latch);
      nc += int'(bus1.controller_clk);
    end while (!bus1.valid && (cyc - c0) < 300);
    lat = cyc - c0;
  endtask

  initial begin
    int c, lat, nb, nl, nc, nv, v_first, v_second;
    logic [B2-1:0] cpu_exp [4];

    bus1.poll_start = 1'b0; bus1.cpu_index = '0;
    bus2.poll_start = 1'b0; bus2.cpu_index = '0;
    pad1[0] = 8'h89;   pad1[1] = 8'h26;
    pad2[0] = 12'hA5C; pad2[1] = 12'h3F1; pad2[2] = 12'h801;

    repeat (3) @(negedge clk_1);
    check("rst busy",    64'(bus1.busy), 0);
    check("rst valid",   64'(bus1.valid), 0);
    check("rst clk",     64'(bus1.controller_clk), 0);
    check("rst latch",   64'(bus1.controller_latch), 0);
    check("rst buttons", 64'(bus1.buttons_out), 0);
    check("rst edge",    64'(bus1.pressed_edge), 0);
    check("rst cpu",     64'(bus1.cpu_buttons), 0);

    // Instance 2: explicit poll, then two self-started polls 50 idle cycles apart.
    rst = 1'b0;
    c = cyc;
    bus2.poll_start = 1'b1;
    @(negedge clk_1);
    bus2.poll_start = 1'b0;
    for (int k = 0; k < 60 && v2_cnt < 1; k++) @(negedge clk_1);
    @(negedge clk_1);
    check("p2 latency", 64'(v2_at[0] - c), 26);
    check("p2 buttons", 64'(bus2.buttons_out), 36'h801_3F1_A5C);
    check("p2 edge1",   64'(bus2.pressed_edge), EDGE ? 36'h801_3F1_A5C : 36'h0);
    for (int k = 0; k < 400 && v2_cnt < 3; k++) @(negedge clk_1);
    check("p2 auto int1", 64'(v2_at[1] - v2_at[0]), 76);
    check("p2 auto int2", 64'(v2_at[2] - v2_at[1]), 76);
    @(negedge clk_1);
    check("p2 edge3", 64'(bus2.pressed_edge), 0);
    cpu_exp[0] = 12'hA5C; cpu_exp[1] = 12'h3F1; cpu_exp[2] = 12'h801; cpu_exp[3] = 12'h000;
    for (int i = 0; i < 4; i++) begin
      bus2.cpu_index = 2'(i);
      #1;
      check($sformatf("p2 cpu idx%0d", i), 64'(bus2.cpu_buttons), 64'(cpu_exp[i]));
    end

    // Instance 1: one poll, latency and waveform shape.
    @(negedge clk_1);
    poll1(lat, nb, nl, nc);
    check("p1 latency",    64'(lat), 35);
    check("p1 busy cyc",   64'(nb), 35);
    check("p1 latch cyc",  64'(nl), 4);
    check("p1 clk hi cyc", 64'(nc), 14);
    @(negedge clk_1);
    check("p1 buttons",  64'(bus1.buttons_out), 16'h2689);
    check("p1 edge",     64'(bus1.pressed_edge), EDGE ? 16'h2689 : 16'h0);
    check("p1 idle sig", 64'({bus1.busy, bus1.valid, bus1.controller_clk, bus1.controller_latch}), 0);
    bus1.cpu_index = 1'b0;
    #1 check("p1 cpu idx0", 64'(bus1.cpu_buttons), 8'h89);
    bus1.cpu_index = 1'b1;
    #1 check("p1 cpu idx1", 64'(bus1.cpu_buttons), 8'h26);

    // Starts at +10 and in the DONE cycle are dropped; the one right after DONE is taken.
    @(negedge clk_1);
    pad1[0] = 8'h8B; pad1[1] = 8'h00;
    c = cyc; nv = 0; v_first = -1; v_second = -1;
    for (int k = 0; k < 72; k++) begin
      bus1.poll_start = (k == 0 || k == 10 || k == 35 || k == 36);
      if (k == 36) begin
        check("p3 buttons a", 64'(bus1.buttons_out), 16'h008B);
        check("p3 edge a",    64'(bus1.pressed_edge), EDGE ? 16'h0002 : 16'h0);
        pad1[0] = 8'h55; pad1[1] = 8'hAA;
      end
      @(negedge clk_1);
      if (bus1.valid) begin
        nv++;
        if (v_first < 0) v_first = cyc - c;
        else v_second = cyc - c;
      end
    end
    bus1.poll_start = 1'b0;
    check("p3 valid cnt", 64'(nv), 2);
    check("p3 valid 1st", 64'(v_first), 35);
    check("p3 valid 2nd", 64'(v_second), 71);
    check("p3 buttons b", 64'(bus1.buttons_out), 16'hAA55);
    check("p3 edge b",    64'(bus1.pressed_edge), EDGE ? 16'hAA54 : 16'h0);

    // Reset 20 cycles into a poll aborts it; the following poll runs normally.
    pad1[0] = 8'h89; pad1[1] = 8'h26;
    @(negedge clk_1);
    bus1.poll_start = 1'b1;
    @(negedge clk_1);
    bus1.poll_start = 1'b0;
    repeat (19) @(negedge clk_1);
    check("p4 busy pre", 64'(bus1.busy), 1);
    rst = 1'b1;
    @(negedge clk_1);
    check("p4 rst sig", 64'({bus1.busy, bus1.valid, bus1.controller_clk, bus1.controller_latch}), 0);
    check("p4 rst buttons", 64'(bus1.buttons_out), 0);
    check("p4 rst edge",    64'(bus1.pressed_edge), 0);
    rst = 1'b0;
    @(negedge clk_1);
    poll1(lat, nb, nl, nc);
    check("p4 latency", 64'(lat), 35);
    @(negedge clk_1);
    check("p4 buttons", 64'(bus1.buttons_out), 16'h2689);
    check("p4 edge",    64'(bus1.pressed_edge), EDGE ? 16'h2689 : 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
